dmem_arbiter: RTL

- Serializes data-memory accesses from the two ALU lanes onto the single dmem port.
- Sits between the two execute lanes and the data memory.
- When both lanes issue a load/store in the same cycle, lane 0 (older in program order) goes first.
- Asserts stall toward PC/decoder until the second access has issued; returns load data with lane/destination tags for register write-back.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Serializes the two execute lanes' load/store requests onto one data-memory port.
// Lane 0 issues first when both lanes request together; load results return tagged for write-back.
module dmem_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic [RW-1:0] rd0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic [RW-1:0] rd1,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic          wb_lane,
  output logic [RW-1:0] wb_reg,
  output logic [DW-1:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_A = 2'd1,
    ISSUE_B = 2'd2
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
    logic          lane;
  } slot_t;

  state_t        state;
  state_t        state_nxt;
  slot_t         slot_a;
  slot_t         slot_b;
  slot_t         lane0_slot;
  slot_t         lane1_slot;
  logic          b_valid;
  logic          accept;
  logic          issue_lane;
  logic [RW-1:0] issue_rd;

  assign lane0_slot = '{we: we0, addr: addr0, wdata: wdata0, rd: rd0, lane: 1'b0};
  assign lane1_slot = '{we: we1, addr: addr1, wdata: wdata1, rd: rd1, lane: 1'b1};

  // New work is only taken while the front end is not held and no redirect is pending.
  assign accept = !stall && !flush && (req0 || req1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? ISSUE_A : IDLE;
      ISSUE_A: begin
        if (b_valid) begin
          state_nxt = ISSUE_B;
        end else begin
          state_nxt = accept ? ISSUE_A : IDLE;
        end
      end
      ISSUE_B: state_nxt = accept ? ISSUE_A : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // Output logic: the memory port is a mux of the slot registers selected by state.
  always_comb begin
    stall      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    issue_rd   = '0;
    issue_lane = 1'b0;
    unique case (state)
      ISSUE_A: begin
        stall      = b_valid;
        mem_en     = 1'b1;
        mem_we     = slot_a.we;
        mem_addr   = slot_a.addr;
        mem_wdata  = slot_a.wdata;
        issue_rd   = slot_a.rd;
        issue_lane = slot_a.lane;
      end
      ISSUE_B: begin
        mem_en     = 1'b1;
        mem_we     = slot_b.we;
        mem_addr   = slot_b.addr;
        mem_wdata  = slot_b.wdata;
        issue_rd   = slot_b.rd;
        issue_lane = slot_b.lane;
      end
      default: begin
      end
    endcase
  end

  // Request capture; B is only ever lane 1 of a paired request and is dropped on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_a  <= '0;
      slot_b  <= '0;
      b_valid <= 1'b0;
    end else begin
      b_valid <= accept && req0 && req1;
      if (accept) begin
        slot_a <= req0 ? lane0_slot : lane1_slot;
        slot_b <= lane1_slot;
      end
    end
  end

  // Write-back tag for the read issued this cycle; data arrives from memory next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_lane  <= 1'b0;
      wb_reg   <= '0;
    end else begin
      wb_valid <= mem_en && !mem_we && (issue_rd != '0);
      if (mem_en && !mem_we) begin
        wb_lane <= issue_lane;
        wb_reg  <= issue_rd;
      end
    end
  end

  assign wb_data = wb_valid ? mem_rdata : '0;

endmodule
